// File: rtl/udt_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// udt_tx_arbiter_if
//   One AXI-Stream style packet bundle (tdata/tkeep/tvalid/tlast + tready).
//   master : the side that drives data and takes tready back
//   slave  : the side that receives data and drives tready
// Parameters
//   DATA_W : tdata width in bits
//   KEEP_W : tkeep width, DATA_W/8
// ---------------------------------------------------------------------------
interface udt_tx_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tkeep, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/udt_tx_arbiter.sv
// ---------------------------------------------------------------------------
// udt_tx_arbiter
//   Merges three packet sources (handshake, control, data) onto one transmit
//   stream. A grant is taken in IDLE and held for a whole packet; after the
//   tlast beat is accepted the FSM returns to IDLE for one bubble cycle.
//   Priority is hs > ctrl > data, except that after MAX_CTRL_BURST hs/ctrl
//   grants made while data was waiting, data is forced through once.
//
// Ports
//   clk        : clock, rising edge
//   core_rst_n : asynchronous active-low reset
//   hs         : handshake-response source   (slave modport)
//   ctrl       : ACK/NAK/keepalive source     (slave modport)
//   data       : data packet source           (slave modport)
//   req        : merged transmit stream       (master modport)
//   data_en    : data source eligibility for new grants
//   grant      : current owner, 0 none / 1 hs / 2 ctrl / 3 data
//   hs_pkt_cnt, ctrl_pkt_cnt, data_pkt_cnt : 32-bit completed-packet
//                counters, present only with UDT_TX_ARB_STATS_EN defined
//
// Optional feature macro: UDT_TX_ARB_STATS_EN
// ---------------------------------------------------------------------------
module udt_tx_arbiter #(
  parameter int DATA_W         = 64,
  parameter int KEEP_W         = 8,
  parameter int MAX_CTRL_BURST = 4    // legal 1..15
) (
  input  logic                    clk,
  input  logic                    core_rst_n,
  udt_tx_arbiter_if.slave         hs,
  udt_tx_arbiter_if.slave         ctrl,
  udt_tx_arbiter_if.slave         data,
  udt_tx_arbiter_if.master        req,
  input  logic                    data_en,
  output logic [1:0]              grant
`ifdef UDT_TX_ARB_STATS_EN
  ,
  output logic [31:0]             hs_pkt_cnt,
  output logic [31:0]             ctrl_pkt_cnt,
  output logic [31:0]             data_pkt_cnt
`endif
);

  // State encoding doubles as the grant output.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HS   = 2'd1,
    S_CTRL = 2'd2,
    S_DATA = 2'd3
  } state_e;

  // Payload carried through the mux (tvalid/tready handled separately).
  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
  } beat_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_CTRL_BURST);

  state_e     state_q, state_d;
  logic [3:0] burst_q, burst_d;

  beat_t hs_beat, ctrl_beat, data_beat, own_beat;
  logic  data_elig;
  logic  force_data;
  logic  pkt_done;

  assign hs_beat   = {hs.tdata,   hs.tkeep,   hs.tlast};
  assign ctrl_beat = {ctrl.tdata, ctrl.tkeep, ctrl.tlast};
  assign data_beat = {data.tdata, data.tkeep, data.tlast};

  assign data_elig  = data.tvalid & data_en;
  // Anti-starvation: data jumps the queue once the burst budget is used up.
  assign force_data = data_elig && (burst_q == BURST_MAX);

  // req.tvalid is only ever the owner's tvalid, and 0 in IDLE, so this is
  // exactly "owner tvalid & tlast & req_tready while granted".
  assign pkt_done = req.tvalid & req.tlast & req.tready;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q <= S_IDLE;
      burst_q <= 4'd0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    unique case (state_q)
      S_IDLE: begin
        if (force_data)       state_d = S_DATA;
        else if (hs.tvalid)   state_d = S_HS;
        else if (ctrl.tvalid) state_d = S_CTRL;
        else if (data_elig)   state_d = S_DATA;

        // Burst count only tracks hs/ctrl grants that actually made data wait.
        if (state_d != S_IDLE) begin
          if (state_d == S_DATA || !data_elig) burst_d = 4'd0;
          else                                 burst_d = burst_q + 4'd1;
        end
      end
      S_HS, S_CTRL, S_DATA: begin
        if (pkt_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: purely combinational mux from the owner
  // -------------------------------------------------------------------------
  always_comb begin
    own_beat    = '0;
    req.tvalid  = 1'b0;
    hs.tready   = 1'b0;
    ctrl.tready = 1'b0;
    data.tready = 1'b0;
    unique case (state_q)
      S_HS: begin
        own_beat   = hs_beat;
        req.tvalid = hs.tvalid;
        hs.tready  = req.tready;
      end
      S_CTRL: begin
        own_beat    = ctrl_beat;
        req.tvalid  = ctrl.tvalid;
        ctrl.tready = req.tready;
      end
      S_DATA: begin
        own_beat    = data_beat;
        req.tvalid  = data.tvalid;
        data.tready = req.tready;
      end
      default: ;
    endcase
    req.tdata = own_beat.tdata;
    req.tkeep = own_beat.tkeep;
    req.tlast = own_beat.tlast;
    grant     = state_q;
  end

`ifdef UDT_TX_ARB_STATS_EN
  // -------------------------------------------------------------------------
  // Completed-packet counters, free-running with natural wrap
  // -------------------------------------------------------------------------
  logic [31:0] hs_cnt_q, ctrl_cnt_q, data_cnt_q;

  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      hs_cnt_q   <= 32'd0;
      ctrl_cnt_q <= 32'd0;
      data_cnt_q <= 32'd0;
    end else if (pkt_done) begin
      unique case (state_q)
        S_HS:    hs_cnt_q   <= hs_cnt_q   + 32'd1;
        S_CTRL:  ctrl_cnt_q <= ctrl_cnt_q + 32'd1;
        S_DATA:  data_cnt_q <= data_cnt_q + 32'd1;
        default: ;
      endcase
    end
  end

  assign hs_pkt_cnt   = hs_cnt_q;
  assign ctrl_pkt_cnt = ctrl_cnt_q;
  assign data_pkt_cnt = data_cnt_q;
`endif

endmodule

// File: tb/tb_udt_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_udt_tx_arbiter
//   Directed bench for udt_tx_arbiter (DATA_W=64, MAX_CTRL_BURST=4).
//   Inputs change 1 time unit after the rising edge; outputs are checked
//   after a further settle delay. Stats checks compile in only with
//   UDT_TX_ARB_STATS_EN.
// ---------------------------------------------------------------------------
module tb_udt_tx_arbiter;
  localparam int DW = 64;
  localparam int KW = 8;

  logic       clk = 1'b0;
  logic       core_rst_n;
  logic       data_en;
  logic [1:0] grant;
`ifdef UDT_TX_ARB_STATS_EN
  logic [31:0] hs_pkt_cnt, ctrl_pkt_cnt, data_pkt_cnt;
`endif

  udt_tx_arbiter_if #(.DATA_W(DW), .KEEP_W(KW)) hs_if ();
  udt_tx_arbiter_if #(.DATA_W(DW), .KEEP_W(KW)) ctrl_if ();
  udt_tx_arbiter_if #(.DATA_W(DW), .KEEP_W(KW)) data_if ();
  udt_tx_arbiter_if #(.DATA_W(DW), .KEEP_W(KW)) req_if ();

  udt_tx_arbiter #(.DATA_W(DW), .KEEP_W(KW), .MAX_CTRL_BURST(4)) dut (
    .clk        (clk),
    .core_rst_n (core_rst_n),
    .hs         (hs_if),
    .ctrl       (ctrl_if),
    .data       (data_if),
    .req        (req_if),
    .data_en    (data_en),
    .grant      (grant)
`ifdef UDT_TX_ARB_STATS_EN
    ,
    .hs_pkt_cnt   (hs_pkt_cnt),
    .ctrl_pkt_cnt (ctrl_pkt_cnt),
    .data_pkt_cnt (data_pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // src: 0 hs, 1 ctrl, 2 data. tkeep is FF on body beats, 0F on the last.
  task automatic drv(input int src, input logic v, input logic [63:0] d, input logic l);
    logic [7:0] k;
    k = l ? 8'h0F : 8'hFF;
    case (src)
      0: begin hs_if.tvalid = v;   hs_if.tdata = d;   hs_if.tlast = l;   hs_if.tkeep = k;   end
      1: begin ctrl_if.tvalid = v; ctrl_if.tdata = d; ctrl_if.tlast = l; ctrl_if.tkeep = k; end
      default: begin data_if.tvalid = v; data_if.tdata = d; data_if.tlast = l; data_if.tkeep = k; end
    endcase
  endtask

  logic [1:0] burst_exp [11];

  initial begin
    burst_exp = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd2};
    core_rst_n    = 1'b0;
    data_en       = 1'b0;
    req_if.tready = 1'b0;
    drv(1, 1'b0, 64'h0, 1'b0);
    drv(2, 1'b0, 64'h0, 1'b0);
    drv(0, 1'b1, 64'hAAAA, 1'b1);   // a valid source must not leak out in reset
    #2;
    chk("rst_grant",    grant, 0);
    chk("rst_tvalid",   req_if.tvalid, 0);
    chk("rst_tdata",    req_if.tdata, 0);
    chk("rst_tkeep",    req_if.tkeep, 0);
    chk("rst_tlast",    req_if.tlast, 0);
    chk("rst_hs_tready", hs_if.tready, 0);
    #20;
    drv(0, 1'b0, 64'h0, 1'b0);
    core_rst_n = 1'b1;
    cyc();

    // ---- hs and data together: hs first, bubble, then data ----
    req_if.tready = 1'b1;
    data_en = 1'b1;
    drv(0, 1'b1, 64'h1111_0001, 1'b0);
    drv(2, 1'b1, 64'h3333_0001, 1'b1);
    settle();
    chk("a_idle_grant",  grant, 0);
    chk("a_idle_tvalid", req_if.tvalid, 0);
    chk("a_idle_hsrdy",  hs_if.tready, 0);
    cyc();
    chk("a_hs_grant",    grant, 1);
    chk("a_hs_tdata1",   req_if.tdata, 64'h1111_0001);
    chk("a_hs_tkeep1",   req_if.tkeep, 8'hFF);
    chk("a_hs_hsrdy",    hs_if.tready, 1);
    chk("a_hs_datardy",  data_if.tready, 0);
    drv(0, 1'b1, 64'h1111_0002, 1'b1);
    settle();
    chk("a_hs_tdata2",   req_if.tdata, 64'h1111_0002);
    chk("a_hs_tlast2",   req_if.tlast, 1);
    chk("a_hs_tkeep2",   req_if.tkeep, 8'h0F);
    cyc();
    drv(0, 1'b0, 64'h0, 1'b0);
    settle();
    chk("a_bubble_grant",  grant, 0);
    chk("a_bubble_tvalid", req_if.tvalid, 0);
    cyc();
    chk("a_data_grant",  grant, 3);
    chk("a_data_tdata",  req_if.tdata, 64'h3333_0001);
    chk("a_data_rdy",    data_if.tready, 1);
    cyc();
    drv(2, 1'b0, 64'h0, 1'b0);
    settle();
    chk("a_end_grant", grant, 0);

    // ---- data_en gating ----
    data_en = 1'b0;
    drv(2, 1'b1, 64'h3333_0002, 1'b1);
    settle();
    cyc();
    chk("b_off_grant1", grant, 0);
    chk("b_off_rdy1",   data_if.tready, 0);
    cyc();
    chk("b_off_grant2", grant, 0);
    chk("b_off_rdy2",   data_if.tready, 0);
    data_en = 1'b1;
    settle();
    chk("b_en_same_cycle", grant, 0);
    cyc();
    chk("b_en_grant", grant, 3);
    chk("b_en_tdata", req_if.tdata, 64'h3333_0002);
    cyc();
    drv(2, 1'b0, 64'h0, 1'b0);
    settle();
    chk("b_end_grant", grant, 0);

    // ---- 3-beat ctrl packet with source stall and sink backpressure ----
    drv(1, 1'b1, 64'h5555_0001, 1'b0);
    cyc();
    chk("c_grant1", grant, 2);
    chk("c_tdata1", req_if.tdata, 64'h5555_0001);
    cyc();
    drv(1, 1'b0, 64'h0, 1'b0);
    settle();
    chk("c_stall_grant",  grant, 2);
    chk("c_stall_tvalid", req_if.tvalid, 0);
    cyc();
    chk("c_stall_hold", grant, 2);
    drv(1, 1'b1, 64'h5555_0002, 1'b0);
    req_if.tready = 1'b0;
    settle();
    chk("c_bp_tdata0", req_if.tdata, 64'h5555_0002);
    chk("c_bp_rdy0",   ctrl_if.tready, 0);
    chk("c_bp_tvalid0", req_if.tvalid, 1);
    cyc();
    chk("c_bp_tdata1", req_if.tdata, 64'h5555_0002);
    chk("c_bp_grant1", grant, 2);
    cyc();
    chk("c_bp_tdata2", req_if.tdata, 64'h5555_0002);
    chk("c_bp_grant2", grant, 2);
    req_if.tready = 1'b1;
    settle();
    chk("c_bp_release_rdy", ctrl_if.tready, 1);
    cyc();
    drv(1, 1'b1, 64'h5555_0003, 1'b1);
    settle();
    chk("c_b3_grant", grant, 2);
    chk("c_b3_tdata", req_if.tdata, 64'h5555_0003);
    chk("c_b3_tlast", req_if.tlast, 1);
    cyc();
    drv(1, 1'b0, 64'h0, 1'b0);
    settle();
    chk("c_end_grant", grant, 0);

    // ---- ctrl burst limit: 2,2,2,2 then forced data ----
    drv(1, 1'b1, 64'h6666_0000, 1'b1);
    drv(2, 1'b1, 64'h7777_0000, 1'b1);
    settle();
    for (int i = 0; i < 11; i++) begin
      cyc();
      chk($sformatf("d_burst_%0d", i), grant, burst_exp[i]);
    end
    cyc();
    drv(1, 1'b0, 64'h0, 1'b0);
    drv(2, 1'b0, 64'h0, 1'b0);
    settle();
    chk("d_end_grant", grant, 0);

    // ---- reset mid data packet, pending hs granted after release ----
    drv(2, 1'b1, 64'h8888_0001, 1'b0);
    cyc();
    chk("e_data_grant", grant, 3);
    cyc();
    drv(2, 1'b1, 64'h8888_0002, 1'b0);
    drv(0, 1'b1, 64'h9999_0009, 1'b1);
    settle();
    chk("e_beat2_grant", grant, 3);
    chk("e_beat2_tdata", req_if.tdata, 64'h8888_0002);
    chk("e_beat2_hsrdy", hs_if.tready, 0);
    #1;
    core_rst_n = 1'b0;
    #1;
    chk("e_async_grant",  grant, 0);
    chk("e_async_tvalid", req_if.tvalid, 0);
    chk("e_async_tdata",  req_if.tdata, 0);
    chk("e_async_rdy",    data_if.tready, 0);
    drv(2, 1'b0, 64'h0, 1'b0);
    cyc();
    chk("e_in_rst_grant", grant, 0);
    #2;
    core_rst_n = 1'b1;
    cyc();
    chk("e_post_grant", grant, 1);
    chk("e_post_tdata", req_if.tdata, 64'h9999_0009);
`ifdef UDT_TX_ARB_STATS_EN
    chk("e_cnt_hs0",   hs_pkt_cnt, 0);
    chk("e_cnt_data0", data_pkt_cnt, 0);
`endif
    cyc();
    drv(0, 1'b0, 64'h0, 1'b0);
    settle();
    chk("e_end_grant", grant, 0);

    // ---- hs over ctrl, then data_en drop mid data packet ----
    drv(0, 1'b1, 64'hA000_0001, 1'b1);
    drv(1, 1'b1, 64'hB000_0001, 1'b1);
    cyc();
    chk("f_hs_first", grant, 1);
    cyc();
    drv(0, 1'b0, 64'h0, 1'b0);
    cyc();
    chk("f_ctrl_next", grant, 2);
    cyc();
    drv(1, 1'b0, 64'h0, 1'b0);
    settle();
    chk("f_idle", grant, 0);
    drv(2, 1'b1, 64'hC000_0001, 1'b0);
    cyc();
    chk("f_data_grant", grant, 3);
    data_en = 1'b0;
    settle();
    chk("f_en_off_rdy",    data_if.tready, 1);
    chk("f_en_off_tvalid", req_if.tvalid, 1);
    cyc();
    drv(2, 1'b1, 64'hC000_0002, 1'b1);
    settle();
    chk("f_en_off_held",  grant, 3);
    chk("f_en_off_tdata", req_if.tdata, 64'hC000_0002);
    cyc();
    drv(2, 1'b0, 64'h0, 1'b0);
    data_en = 1'b1;
    settle();
    chk("f_end_grant", grant, 0);

    // ---- fresh reset, then 5 hs and 3 data packets ----
    core_rst_n = 1'b0;
    #1;
`ifdef UDT_TX_ARB_STATS_EN
    chk("g_rst_cnt_hs",   hs_pkt_cnt, 0);
    chk("g_rst_cnt_ctrl", ctrl_pkt_cnt, 0);
    chk("g_rst_cnt_data", data_pkt_cnt, 0);
`endif
    #1;
    core_rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      drv(0, 1'b1, 64'hD000_0000 + 64'(i), 1'b1);
      cyc();
      chk($sformatf("g_hs_grant_%0d", i), grant, 1);
      cyc();
      drv(0, 1'b0, 64'h0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      drv(2, 1'b1, 64'hE000_0000 + 64'(i), 1'b1);
      cyc();
      chk($sformatf("g_data_grant_%0d", i), grant, 3);
      cyc();
      drv(2, 1'b0, 64'h0, 1'b0);
    end
    settle();
    chk("g_end_grant", grant, 0);
`ifdef UDT_TX_ARB_STATS_EN
    chk("g_cnt_hs",   hs_pkt_cnt, 5);
    chk("g_cnt_ctrl", ctrl_pkt_cnt, 0);
    chk("g_cnt_data", data_pkt_cnt, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/udt_tx_arbiter.md
UDT_TX_ARBITER -- requirements
Module: udt_tx_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, stream data width in bits.
REQ-002 SHALL have parameter KEEP_W, default 8, byte-enable width, DATA_W/8.
REQ-003 SHALL have parameter MAX_CTRL_BURST, default 4, number of consecutive control packets allowed before a waiting data packet is forced through. Legal range is 1-15.
REQ-004 SHALL have port clk, input, 1, the only clock; all logic is rising-edge.
REQ-005 SHALL have port core_rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have source bundle hs_tdata/hs_tkeep/hs_tvalid/hs_tlast, input, DATA_W/KEEP_W/1/1, handshake-response packet source; hs_tready, output, 1.
REQ-007 SHALL have source bundle ctrl_tdata/ctrl_tkeep/ctrl_tvalid/ctrl_tlast, input, DATA_W/KEEP_W/1/1, ACK/NAK/keepalive packet source; ctrl_tready, output, 1.
REQ-008 SHALL have source bundle data_tdata/data_tkeep/data_tvalid/data_tlast, input, DATA_W/KEEP_W/1/1, data packet source; data_tready, output, 1.
REQ-009 SHALL have sink bundle req_tdata/req_tkeep/req_tvalid/req_tlast, output, DATA_W/KEEP_W/1/1, merged transmit stream; req_tready, input, 1.
REQ-010 SHALL have port data_en, input, 1, data-source eligibility; low blocks new data grants, for example during close.
REQ-011 SHALL have port grant, output, 2, the current owner: 0 none, 1 hs, 2 ctrl, 3 data.

Function
REQ-012 SHALL implement an FSM with states IDLE, HS, CTRL and DATA, encoded in grant.
REQ-013 In IDLE, SHALL drive req_tvalid=0 and all source tready=0.
REQ-014 In IDLE, SHALL move in one cycle to the winner among the eligible valids: hs_tvalid; ctrl_tvalid; data_tvalid only while data_en=1.
REQ-015 Priority SHALL be hs over ctrl over data, except per REQ-016.
REQ-016 When burst_cnt equals MAX_CTRL_BURST and data is eligible, data SHALL win over hs and ctrl.
REQ-017 burst_cnt, 4 bits, SHALL increment on each hs or ctrl grant made while data was eligible.
REQ-018 burst_cnt SHALL clear on a data grant, or on any grant made while data was not eligible.
REQ-019 In a granted state, req_* SHALL equal the owner's tdata/tkeep/tvalid/tlast combinationally.
REQ-020 In a granted state, the owner's tready SHALL equal req_tready; non-owners' tready SHALL be 0.
REQ-021 The FSM SHALL leave a granted state only on owner tvalid & tlast & req_tready, and then go to IDLE. This gives one bubble cycle between packets.
REQ-022 Latency from a source tvalid rising in IDLE to req_tvalid SHALL be exactly 1 cycle.
REQ-023 A grant SHALL be held for the whole packet. Deasserting data_en mid-packet SHALL NOT truncate a data packet already granted.
REQ-024 A granted source with tvalid low SHALL stall the output (req_tvalid=0) without releasing the grant.
REQ-025 A single-beat packet (tlast on the first beat) SHALL be legal and SHALL release after that one beat.
REQ-026 req_tdata, req_tkeep and req_tlast SHALL be held stable while req_tvalid=1 and req_tready=0, following AXI-Stream rules, given a compliant source.

Reset
REQ-027 While core_rst_n=0, the block SHALL immediately force state=IDLE, grant=0, burst_cnt=0, req_tvalid=0, req_tdata=0, req_tkeep=0, req_tlast=0, all tready=0, and all stats counters to 0.
REQ-028 Reset mid-packet SHALL abandon the packet; after release, arbitration SHALL restart from IDLE.

Configuration
REQ-029 With macro UDT_TX_ARB_STATS_EN defined, the block SHALL add outputs hs_pkt_cnt, ctrl_pkt_cnt and data_pkt_cnt, each 32 bits.
REQ-030 Each stats counter SHALL increment by 1 on each completed packet of its source (tvalid & tlast & req_tready while granted), wrapping 0xFFFFFFFF to 0.
REQ-031 Without UDT_TX_ARB_STATS_EN, these ports and counters SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-032 hs and data valid together in IDLE, req_tready=1 -> grant=1 next cycle; hs packet passes; IDLE; then grant=3.
REQ-033 ctrl continuously valid with 1-beat packets, data valid, data_en=1, MAX_CTRL_BURST=4 -> grant sequence 2,2,2,2,3,2...
REQ-034 data_en=0, only data valid -> grant stays 0 and data_tready stays 0; data_en=1 -> grant=3 one cycle later.
REQ-035 3-beat ctrl packet with req_tready low for 2 cycles on beat 2 -> beat 2 held stable; grant=2 until beat 3 is accepted.
REQ-036 core_rst_n pulsed low during beat 2 of a data packet -> req_tvalid=0 and grant=0 asynchronously; a pending hs is granted 1 cycle after release.
REQ-037 With UDT_TX_ARB_STATS_EN defined: 5 hs and 3 data packets -> hs_pkt_cnt=5, data_pkt_cnt=3, ctrl_pkt_cnt=0.
